// File: rtl/contador_arbitro_if.sv
// Request/grant and counter-control bundle between the requesters, contador_arbitro and one contador.
// Both requester ports and the counter port sit in one bundle so the arbiter has a single modport.
interface contador_arbitro_if #(
    parameter int unsigned BITS    = 4,
    parameter int unsigned PASOS_W = 4
);
    logic               REQ0;
    logic               REQ1;
    logic [1:0]         MODO0;
    logic [1:0]         MODO1;
    logic [BITS-1:0]    D0;
    logic [BITS-1:0]    D1;
    logic [PASOS_W-1:0] PASOS0;
    logic [PASOS_W-1:0] PASOS1;
    logic               ACK0;
    logic               ACK1;
    logic               DONE0;
    logic               DONE1;
    logic [BITS-1:0]    RESULT;
    logic [BITS-1:0]    Q_CNT;
    logic               C_ENB;
    logic [1:0]         C_MODO;
    logic [BITS-1:0]    C_D;

    // Requesters plus the attached counter.
    modport master (
        output REQ0, REQ1, MODO0, MODO1, D0, D1, PASOS0, PASOS1, Q_CNT,
        input  ACK0, ACK1, DONE0, DONE1, RESULT, C_ENB, C_MODO, C_D
    );

    // The arbiter itself.
    modport slave (
        input  REQ0, REQ1, MODO0, MODO1, D0, D1, PASOS0, PASOS1, Q_CNT,
        output ACK0, ACK1, DONE0, DONE1, RESULT, C_ENB, C_MODO, C_D
    );
endinterface

// File: rtl/contador_arbitro.sv
// Shares one contador between two requesters: round-robin grant, load-then-count sequencing, result return.
// Define CONTADOR_ARB_FIXED_PRIO_EN to make requester 0 always win simultaneous requests.
module contador_arbitro #(
    parameter int unsigned BITS    = 4,
    parameter int unsigned PASOS_W = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    contador_arbitro_if.slave   bus
);

    localparam logic [1:0] MODO_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]         modo;
        logic [BITS-1:0]    d;
        logic [PASOS_W-1:0] pasos;
    } job_t;

    state_t             state;
    state_t             state_nxt;
    job_t               job;
    job_t               req_job;
    logic               owner;
    logic [PASOS_W-1:0] steps;
    logic               grant_any;
    logic               grant_id;
`ifndef CONTADOR_ARB_FIXED_PRIO_EN
    logic               ptr;
`endif

    // Arbitration: a lone requester wins; on contention the pointer (or requester 0) decides.
    always_comb begin
        grant_any = bus.REQ0 | bus.REQ1;
`ifdef CONTADOR_ARB_FIXED_PRIO_EN
        grant_id  = bus.REQ1 & ~bus.REQ0;
`else
        grant_id  = (bus.REQ0 & bus.REQ1) ? ptr : bus.REQ1;
`endif
        req_job   = grant_id ? job_t'({bus.MODO1, bus.D1, bus.PASOS1})
                             : job_t'({bus.MODO0, bus.D0, bus.PASOS0});
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if ((job.modo != MODO_LOAD) && (job.pasos != PASOS_W'(0))) begin
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_FIN;
                end
            end
            S_RUN: begin
                if (steps == PASOS_W'(1)) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Job latch, step counter, result capture, completion pulse and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            job        <= '0;
            owner      <= 1'b0;
            steps      <= '0;
            bus.RESULT <= '0;
            bus.DONE0  <= 1'b0;
            bus.DONE1  <= 1'b0;
`ifndef CONTADOR_ARB_FIXED_PRIO_EN
            ptr        <= 1'b0;
`endif
        end else begin
            bus.DONE0 <= 1'b0;
            bus.DONE1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        job   <= req_job;
                        owner <= grant_id;
                        steps <= req_job.pasos;
                    end
                end
                S_RUN: begin
                    steps <= steps - PASOS_W'(1);
                end
                S_FIN: begin
                    // Q_CNT already holds the value produced by the last RUN edge.
                    bus.RESULT <= bus.Q_CNT;
                    bus.DONE0  <= ~owner;
                    bus.DONE1  <= owner;
`ifndef CONTADOR_ARB_FIXED_PRIO_EN
                    ptr        <= ~owner;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    // Counter control and grant decoded from registered state only.
    always_comb begin
        bus.ACK0   = 1'b0;
        bus.ACK1   = 1'b0;
        bus.C_ENB  = 1'b0;
        bus.C_MODO = 2'b00;
        bus.C_D    = '0;
        case (state)
            S_LOAD: begin
                bus.ACK0   = ~owner;
                bus.ACK1   = owner;
                bus.C_ENB  = 1'b1;
                bus.C_MODO = MODO_LOAD;
                bus.C_D    = job.d;
            end
            S_RUN: begin
                bus.C_ENB  = 1'b1;
                bus.C_MODO = job.modo;
                bus.C_D    = job.d;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/contador_arbitro.md
# contador_arbitro

Controller that shares one 4-bit `contador` (up, down, down-by-3, parallel load) between two requesters. Each requester submits a job: load value, counting mode and step count. The block grants the counter round-robin, sequences the counter's `ENB`/`MODO`/`D` inputs through load-then-count, and returns the final count value with a completion pulse. It sits between the requesting blocks and a single `contador` instance, and is the only driver of that instance's control inputs.

## Interface
- `BITS`, default 4: counter data width; must match the attached `contador`.
- `PASOS_W`, default 4: width of the step-count field.
- `CLK` input 1: clock; all state changes on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `REQ0`, `REQ1` input 1: job request; held high until the matching ACK.
- `MODO0`, `MODO1` input 2: requested counter mode (00 up, 01 down, 10 down by 3, 11 load only).
- `D0`, `D1` input BITS: initial value loaded into the counter.
- `PASOS0`, `PASOS1` input PASOS_W: number of counting steps after the load.
- `ACK0`, `ACK1` output 1: one-cycle grant pulse; the job fields are latched in this cycle.
- `DONE0`, `DONE1` output 1: one-cycle completion pulse.
- `RESULT` output BITS: counter value at the end of the last completed job.
- `Q_CNT` input BITS: `Q` of the attached counter.
- `C_ENB` output 1: drives the counter's `ENB`.
- `C_MODO` output 2: drives the counter's `MODO`.
- `C_D` output BITS: drives the counter's `D`.

## Operation
- FSM states: IDLE, LOAD, RUN, FIN.
- **IDLE**
  - `C_ENB`=0.
  - If any REQ is high, grant per the arbitration rule, latch the winner's MODO/D/PASOS and owner ID, then go to LOAD.
- **LOAD** (1 cycle)
  - `ACK<owner>`=1, `C_ENB`=1, `C_MODO`=11, `C_D`=latched D.
  - Go to RUN if the latched MODO≠11 and PASOS≠0; otherwise go to FIN.
- **RUN**
  - `C_ENB`=1, `C_MODO`=latched MODO, `C_D`=latched D.
  - An internal step counter decrements once per cycle.
  - Leave RUN after exactly PASOS cycles; go to FIN.
- **FIN** (1 cycle)
  - `C_ENB`=0.
  - Capture `Q_CNT` into RESULT.
  - Set a registered `DONE<owner>` pulse.
  - Flip the round-robin pointer to the non-owner.
  - Go to IDLE.
- **Arbitration**
  - Only one requester high: it wins.
  - Both high: the requester named by the round-robin pointer wins.
  - The pointer resets to 0 (requester 0 first).
- **Requester rules**
  - Deassert REQ after ACK.
  - REQ still high in IDLE after DONE is treated as a new job.
  - REQ changes while not in IDLE are ignored.
- **Arithmetic**
  - The counter wraps modulo 2^BITS.
  - The controller does no range check: 0 down by 3 yields 13 (BITS=4).
- **Counter reset**
  - The counter has no reset of its own.
  - Every job starts with LOAD, so a stale counter state never reaches RESULT.
- **Outputs**
  - C_* and ACK are decoded from registered state only.
  - There is no combinational path from any input to any output.

## Timing
- REQ high in IDLE at cycle t gives:
  - LOAD/ACK at t+1.
  - RUN at t+2 … t+1+N.
  - FIN at t+2+N.
  - DONE pulse and new RESULT at t+3+N.
- N=0 or MODO=11: FIN at t+2, DONE at t+3.
- The DONE cycle coincides with IDLE, so a pending request is granted in that same cycle; its ACK follows at t+4+N. Back-to-back jobs therefore have a 1-cycle IDLE gap between FIN and the next LOAD.
- `Q_CNT` in FIN reflects the last RUN edge, because the counter registers its output one cycle after `C_ENB`.
- Reset values:
  - state=IDLE, pointer=0.
  - `ACK*`=0, `DONE*`=0, `RESULT`=0.
  - `C_ENB`=0, `C_MODO`=00, `C_D`=0.
- RESET mid-job aborts the job: no DONE is issued, and the counter is left frozen (ENB=0).
- RESET has priority over all other events in the same cycle.

## Configuration
- `CONTADOR_ARB_FIXED_PRIO_EN`
  - Defined: requester 0 always wins simultaneous requests, and the pointer is not used.
  - Undefined (default): round-robin as above.

## Test plan
- Load-and-count up: REQ0, MODO0=00, D0=5, PASOS0=3 → ACK0 at t+1, C_ENB high 4 cycles, DONE0 at t+6, RESULT=8.
- Down-by-3 with wrap: REQ1, MODO1=10, D1=1, PASOS1=2 → RESULT=11 (1→14→11), DONE1 at t+5.
- Edge steps: MODO=11 with D=9, and separately PASOS=0 with MODO=01 and D=9 → DONE at t+3, RESULT=9, no RUN cycles.
- Contention: REQ0 and REQ1 held high from reset → served in order 0, 1, 0, 1. With `CONTADOR_ARB_FIXED_PRIO_EN` defined → 0, 0, 0.
- Reset mid-RUN: assert RESET during the 2nd RUN cycle of a PASOS=8 job → next cycle IDLE, all outputs at reset values, no DONE; a new job then completes correctly.
